// File: rtl/sync_fifo_pkg.sv
// Shared constants, types and helpers for the parametrised synchronous FIFO.
// The optional first-word fall-through mode is selected with SYNC_FIFO_FWFT_EN.
package sync_fifo_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_DEPTH    = 8;
  localparam int DEF_AE_LEVEL = 1;

  // Pointer and count width: one extra bit so DEPTH itself and the wrap state are representable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bus of sync_fifo_param: write/read requests, read data and status.
interface sync_fifo_param_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) ();

  logic                      w_en;
  logic [DATA_W-1:0]         data_in;
  logic                      r_en;
  logic [DATA_W-1:0]         data_out;
  logic                      full;
  logic                      empty;
  logic                      almost_full;
  logic                      almost_empty;
  logic [ptr_w(DEPTH)-1:0]   count;
  logic                      overflow;
  logic                      underflow;

  modport master (
    output w_en, data_in, r_en,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  w_en, data_in, r_en,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_ram.sv
// DEPTH x DATA_W storage with one synchronous write port. The read port is registered,
// or combinational when SYNC_FIFO_FWFT_EN is defined.
module sync_fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset; clearing it would only cost area, as no entry is read before it is written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rd_data = mem[rd_addr];

  logic unused_rd_ctrl;
  assign unused_rd_ctrl = &{1'b0, rd_en, rst_n};
`else
  // NOTE: reset is synchronous here; rst_n is sampled on the clock edge like any other input.
  always_ff @(posedge clk) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags and
// overflow/underflow pulses. Define SYNC_FIFO_FWFT_EN for first-word fall-through reads.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic              clk,
  input  logic              rst_n,
  sync_fifo_param_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW-1:0] AF_CNT = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_CNT = PW'(AE_LEVEL);

  logic [PW-1:0] wr_ptr, rd_ptr, count_q;
  logic          full, empty;
  logic          wr_ok, rd_ok;
  logic          overflow_q, underflow_q;

  // Same index with opposite wrap bits means the writer is a whole lap ahead.
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[PW-1] != rd_ptr[PW-1]);
  assign empty = (wr_ptr == rd_ptr);

  // Acceptance looks only at pre-edge flags, so a full FIFO never takes a write
  // on the strength of a same-cycle read (and likewise for reads when empty).
  assign wr_ok = bus.w_en && !full;
  assign rd_ok = bus.r_en && !empty;

  // NOTE: every register below uses non-blocking assignment so all state updates from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + PW'(1);
        2'b01:   count_q <= count_q - PW'(1);
        default: count_q <= count_q;
      endcase
      overflow_q  <= bus.w_en && full;
      underflow_q <= bus.r_en && empty;
    end
  end

  sync_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (bus.data_in),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (bus.data_out)
  );

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.count        = count_q;
  assign bus.almost_full  = (count_q >= AF_CNT);
  assign bus.almost_empty = (count_q <= AE_CNT);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DEPTH=8, DATA_W=8) against a queue-based model;
// covers both read modes through SYNC_FIFO_FWFT_EN.
module tb_sync_fifo_param;

  localparam int DATA_W   = 8;
  localparam int DEPTH    = 8;
  localparam int AF_LEVEL = 7;
  localparam int AE_LEVEL = 1;

  logic clk;
  logic rst_n;

  sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  sync_fifo_param #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL),
    .AE_LEVEL (AE_LEVEL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: the FIFO contents as a queue plus the expected registered outputs.
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] exp_dout;
  logic              exp_ovf;
  logic              exp_unf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int sz;
    sz = q.size();
    check({tag, ".count"},        32'(bus.count),        32'(sz));
    check({tag, ".full"},         32'(bus.full),         32'(sz == DEPTH));
    check({tag, ".empty"},        32'(bus.empty),        32'(sz == 0));
    check({tag, ".almost_full"},  32'(bus.almost_full),  32'(sz >= AF_LEVEL));
    check({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(sz <= AE_LEVEL));
    check({tag, ".overflow"},     32'(bus.overflow),     32'(exp_ovf));
    check({tag, ".underflow"},    32'(bus.underflow),    32'(exp_unf));
`ifdef SYNC_FIFO_FWFT_EN
    if (sz != 0) check({tag, ".data_out"}, 32'(bus.data_out), 32'(q[0]));
`else
    check({tag, ".data_out"}, 32'(bus.data_out), 32'(exp_dout));
`endif
  endtask

  // One clock cycle of stimulus; the model decides acceptance from pre-edge occupancy.
  task automatic cycle(input bit w, input logic [DATA_W-1:0] d, input bit r, input string tag);
    int sz;
    sz = q.size();
    bus.w_en    = w;
    bus.data_in = d;
    bus.r_en    = r;
    exp_ovf = w && (sz == DEPTH);
    exp_unf = r && (sz == 0);
    if (r && sz != 0)     exp_dout = q.pop_front();
    if (w && sz != DEPTH) q.push_back(d);
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic do_reset(input bit w, input bit r, input string tag);
    rst_n       = 1'b0;
    bus.w_en    = w;
    bus.r_en    = r;
    bus.data_in = 8'hEE;
    @(posedge clk);
    #1;
    q.delete();
    exp_dout = '0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
    check_state(tag);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    bus.w_en    = 1'b0;
    bus.r_en    = 1'b0;
    bus.data_in = '0;
    rst_n       = 1'b0;
    exp_dout    = '0;
    exp_ovf     = 1'b0;
    exp_unf     = 1'b0;
    @(posedge clk);
    #1;
    do_reset(1'b0, 1'b0, "reset");

    // Fill with 0x01..0x08; almost_full from count 7, full at 8.
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, "fill");

    // Write while full: overflow for one cycle, 0xAA dropped.
    cycle(1'b1, 8'hAA, 1'b0, "overflow");
    cycle(1'b0, 8'h00, 1'b0, "overflow_clear");

    // Drain: 0x01..0x08 in order, one cycle after each read.
    for (int i = 1; i <= DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, "drain");

    // Read while empty: underflow for one cycle, data_out held.
    cycle(1'b0, 8'h00, 1'b1, "underflow");
    cycle(1'b0, 8'h00, 1'b0, "underflow_clear");

    // Simultaneous access on empty: write only; on full: read only.
    cycle(1'b1, 8'h33, 1'b1, "both_empty");
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, "refill");
    cycle(1'b1, 8'h77, 1'b1, "both_full");
    while (q.size() > 4) cycle(1'b0, 8'h00, 1'b1, "to_four");

    // Steady state at count 4 for 20 cycles, crossing two pointer wraps.
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'h80 + i), 1'b1, "steady");

    // Reach count 5, then reset in the middle of a burst.
    cycle(1'b1, 8'hC0, 1'b0, "to_five");
    cycle(1'b1, 8'hC1, 1'b1, "burst");
    do_reset(1'b1, 1'b1, "mid_burst_reset");

    // Single write into empty FIFO with r_en low; in fall-through mode 0x5A shows at once.
    cycle(1'b1, 8'h5A, 1'b0, "fwft_write");
    cycle(1'b0, 8'h00, 1'b0, "fwft_hold");
    cycle(1'b0, 8'h00, 1'b1, "fwft_pop");

    // Random traffic with phases biased towards full, towards empty, then balanced.
    for (int p = 0; p < 4; p++) begin
      int wp;
      int rp;
      wp = (p == 0) ? 80 : (p == 1) ? 20 : 50;
      rp = 100 - wp;
      for (int i = 0; i < 60; i++) begin
        d = 8'($urandom);
        cycle($urandom_range(0, 99) < wp, d, $urandom_range(0, 99) < rp, "random");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO that is the next generation of the team's 8x8 synchronous FIFO. It has configurable data width and depth, and every entry is usable. It adds an occupancy count, programmable almost-full/almost-empty flags, and overflow/underflow error pulses. It sits between same-clock producer and consumer datapaths as the standard elastic buffer.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 8, number of storage entries; power of two, >=2
AF_LEVEL, DEPTH-1, almost_full asserted when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 1, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
w_en  in  1  write request
data_in  in  DATA_W  write data
r_en  in  1  read request
data_out  out  DATA_W  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  one-cycle pulse: write attempted while full
underflow  out  1  one-cycle pulse: read attempted while empty

Behaviour:
- Reset: synchronous, active-low, overrides all other activity in that cycle, including mid-burst. After the edge: pointers=0, count=0, data_out=0, overflow=0, underflow=0. Flags are derived from count: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0). Memory contents are not cleared.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits; the MSB is the wrap bit. Index = low bits. Increments wrap naturally at 2*DEPTH.
- full = (index equal AND wrap bits differ). empty = (pointers equal). All DEPTH entries are usable.
- Write accepted iff w_en && !full: mem[wr_idx] <= data_in, wr_ptr+1.
- Read accepted iff r_en && !empty: data_out <= mem[rd_idx], rd_ptr+1. Read latency is 1 cycle. data_out holds its value when no read is accepted.
- Acceptance uses flags sampled before the edge, so neither side sees same-cycle bypass:
  - Full with w_en && r_en: read accepted, write rejected (overflow pulses); count -> DEPTH-1.
  - Empty with w_en && r_en: write accepted, read rejected (underflow pulses); count -> 1.
  - Otherwise both accepted: count unchanged.
- count is registered: +1 on write only, -1 on read only, unchanged on both or neither.
- Flags are combinational from registered count/pointers, so there are no glitches across edges.
- overflow is registered: <= w_en && full. underflow is registered: <= r_en && empty. Each is high for exactly the cycle after the offending request.
- A rejected access never changes pointers, memory, count or data_out.

Optional Feature:
Macro SYNC_FIFO_FWFT_EN (first-word fall-through).
- Defined:
  - data_out presents mem[rd_idx] combinationally whenever !empty.
  - r_en && !empty pops the head; the next word appears in the same cycle the pointer updates.
  - Read latency is 0. data_out is don't-care while empty.
  - A word written into an empty FIFO is visible on data_out the cycle after the write.
- Undefined: registered 1-cycle read behaviour as above.
- Flags, count and error pulses are identical in both modes.

Decomposition:
- Package sync_fifo_pkg:
  - ptr_w(DEPTH) constant function returning $clog2(DEPTH)+1.
  - Default parameter constants.
  - Typedef fifo_status_t {full, empty, almost_full, almost_empty, overflow, underflow} for integrators bundling status.
- Sub-module sync_fifo_ram: DEPTH x DATA_W storage, one synchronous write port. Its read port is registered normally and combinational under SYNC_FIFO_FWFT_EN.
- Pointer, count and flag logic stays in sync_fifo_param.

Test Plan:
- Reset, then write 8 words 0x01..0x08 (DEPTH=8) -> count steps 1..8. full=1 after the 8th write. almost_full=1 from count 7 (AF_LEVEL=7).
- From full, read 8 times -> data_out 0x01..0x08, each one cycle after r_en. empty=1 after the last read. No loss across pointer wrap.
- When full, assert w_en with data 0xAA -> overflow=1 for one cycle; count stays 8. 0xAA is never read back.
- When empty, assert r_en -> underflow=1 for one cycle; data_out unchanged; count stays 0.
- At count=4, assert w_en && r_en together for 20 cycles with incrementing data -> count constant at 4. Output sequence is in order across two pointer wraps.
- Mid-burst at count=5, assert rst_n=0 for one edge -> count=0, empty=1, data_out=0 next cycle. Then run with SYNC_FIFO_FWFT_EN and write 0x5A -> data_out=0x5A with r_en low.
